// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM demodulator chain: default widths,
// pipeline state encodings and a width-generic saturation helper.
package fm_demod_pkg;

    localparam int WIDTH     = 16;
    localparam int OUT_WIDTH = 16;

    // Post-dump pipeline sequencing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILT = 2'd1,
        OUT  = 2'd2
    } pipe_state_t;

    // Clamp a sign-extended value into the signed range of out_w bits.
    // Callers size-cast the result down to out_w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // True when saturate() would have to clamp x
    function automatic logic is_clamped(input logic signed [63:0] x,
                                        input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/audio_decim_deemph_deemph_iir.sv
// First-order shift-based de-emphasis IIR with output gain shift,
// saturation to the audio word and a sticky saturation flag.
module deemph_iir #(
    parameter int IN_W        = 32,
    parameter int ALPHA_SHIFT = 3,
    parameter int GAIN_SHIFT  = 0,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        kick,
    input  logic                        emit,
    input  logic signed [IN_W-1:0]      avg,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        valid_o,
    output logic                        sat_o
);
    import fm_demod_pkg::*;

    // One bit of headroom over the input: the difference avg - y always fits,
    // and y itself only ever moves between its old value and avg.
    localparam int Y_W = IN_W + 1;

    logic signed [Y_W-1:0] y_reg;
    logic signed [Y_W-1:0] avg_ext;
    logic signed [Y_W-1:0] diff;
    logic signed [Y_W-1:0] step;
    logic signed [Y_W-1:0] y_next;
    logic signed [Y_W-1:0] y_scaled;

    // Filter update and output scaling
    always_comb begin
        avg_ext  = $signed({avg[IN_W-1], avg});
        diff     = avg_ext - y_reg;
        step     = diff >>> ALPHA_SHIFT;
        y_next   = y_reg + step;
        y_scaled = y_reg >>> GAIN_SHIFT;
    end

    // Filter state on kick; saturated output, strobe and sticky flag on emit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_reg   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (kick)
                y_reg <= y_next;
            if (emit) begin
                data_o  <= OUT_WIDTH'(saturate(64'(y_scaled), OUT_WIDTH));
                valid_o <= 1'b1;
                if (is_clamped(64'(y_scaled), OUT_WIDTH))
                    sat_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_decim_deemph.sv
// Integrate-and-dump decimator followed by the de-emphasis IIR.
// Accumulation runs independently of the FILT/OUT pipeline.
module audio_decim_deemph #(
    parameter int WIDTH       = fm_demod_pkg::WIDTH,
    parameter int RATIO       = 32,
    parameter int LOG2_RATIO  = 5,
    parameter int ALPHA_SHIFT = 3,
    parameter int GAIN_SHIFT  = 0,
    parameter int OUT_WIDTH   = fm_demod_pkg::OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        valid_i,
    input  logic signed [2*WIDTH-1:0]   data_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        valid_o,
    output logic                        sat_o
);
    import fm_demod_pkg::*;

    localparam int IN_W  = 2 * WIDTH;
    // LOG2_RATIO extra bits: a full block of extreme samples cannot overflow
    localparam int ACC_W = IN_W + LOG2_RATIO;

    logic signed [ACC_W-1:0]  acc_reg;
    logic [LOG2_RATIO-1:0]    count_reg;
    logic signed [IN_W-1:0]   avg_reg;
    pipe_state_t              state_reg;

    logic                     last;
    logic                     dump;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [IN_W-1:0]   avg_next;

    // Block-end detection and the dumped average (floor via arithmetic shift)
    always_comb begin
        last     = (count_reg == LOG2_RATIO'(RATIO - 1));
        dump     = start_i & valid_i & last;
        acc_sum  = acc_reg + ACC_W'(data_i);
        avg_next = IN_W'(acc_sum >>> LOG2_RATIO);
    end

    // Integrate and dump; dropping start_i throws away a partial block
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg   <= '0;
            count_reg <= '0;
            avg_reg   <= '0;
        end else if (!start_i) begin
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (valid_i) begin
            if (last) begin
                acc_reg   <= '0;
                count_reg <= '0;
                avg_reg   <= avg_next;
            end else begin
                acc_reg   <= acc_sum;
                count_reg <= count_reg + LOG2_RATIO'(1);
            end
        end
    end

    // Pipeline sequencing: one filter step, then one output step.
    // A started FILT/OUT sequence completes even if start_i falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (dump) state_reg <= FILT;
                FILT:    state_reg <= OUT;
                OUT:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    deemph_iir #(
        .IN_W        (IN_W),
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .GAIN_SHIFT  (GAIN_SHIFT),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_iir (
        .clk     (clk),
        .rst     (rst),
        .kick    (state_reg == FILT),
        .emit    (state_reg == OUT),
        .avg     (avg_reg),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sat_o   (sat_o)
    );

endmodule

// File: tb/tb_audio_decim_deemph.sv
// Directed bench for audio_decim_deemph with hand-computed expected outputs.
module tb_audio_decim_deemph;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_i = 1'b0;
    logic               valid_i = 1'b0;
    logic signed [31:0] data_i = '0;
    logic signed [15:0] data_o;
    logic               valid_o;
    logic               sat_o;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int consec = 0;
    logic prev_valid = 1'b0;

    logic signed [15:0] outs[$];
    int                 vcyc[$];
    logic               sats[$];

    audio_decim_deemph dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sat_o   (sat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every output strobe, one line per output
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            outs.push_back(data_o);
            vcyc.push_back(cyc);
            sats.push_back(sat_o);
            $display("out #%0d cyc=%0d data_o=%0d sat_o=%0b", outs.size() - 1, cyc, data_o, sat_o);
            if (prev_valid) consec++;
        end
        prev_valid = (valid_o === 1'b1);
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        outs.delete();
        vcyc.delete();
        sats.delete();
    endtask

    // n back-to-back accepted samples of value v; returns 1 time unit after the last edge
    task automatic feed(input logic signed [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            start_i = 1'b1;
            valid_i = 1'b1;
            data_i = v;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
    endtask

    initial begin
        int c0;

        // Reset and idle
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_sat", sat_o, 0);
        rst = 1'b1;
        outs.delete();
        start_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            valid_i = 1'b1;
            data_i = 32'sd500;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_nvalid", outs.size(), 0);
        check("idle_data", data_o, 0);
        check("idle_sat", sat_o, 0);

        // Constant 100
        do_reset();
        c0 = cyc;
        feed(32'sd100, 32 * 40);
        repeat (4) @(posedge clk);
        #1;
        check("c100_count", outs.size(), 40);
        check("c100_out0", outs[0], 12);
        check("c100_out1", outs[1], 23);
        check("c100_out2", outs[2], 32);
        check("c100_out3", outs[3], 40);
        check("c100_out4", outs[4], 47);
        check("c100_out39", outs[39], 93);
        check("c100_latency", vcyc[0], c0 + 34);
        check("c100_spacing", vcyc[1] - vcyc[0], 32);
        check("c100_sat", sat_o, 0);

        // Constant -1
        do_reset();
        feed(-32'sd1, 32 * 3);
        repeat (4) @(posedge clk);
        #1;
        check("m1_count", outs.size(), 3);
        check("m1_out0", outs[0], -1);
        check("m1_out1", outs[1], -1);
        check("m1_out2", outs[2], -1);

        // Saturation up, then down
        do_reset();
        feed(32'sd40000, 32 * 13);
        repeat (4) @(posedge clk);
        #1;
        check("sat_count", outs.size(), 13);
        check("sat_out0", outs[0], 5000);
        check("sat_out11", outs[11], 31941);
        check("sat_flag11", sats[11], 0);
        check("sat_out12", outs[12], 32767);
        check("sat_flag12", sats[12], 1);
        feed(-32'sd40000, 32 * 40);
        repeat (4) @(posedge clk);
        #1;
        check("satn_out_last", outs[outs.size() - 1], -32768);
        check("satn_flag", sat_o, 1);

        // Partial block discarded by a one-cycle start_i drop
        do_reset();
        feed(32'sd1000, 20);
        start_i = 1'b0;
        valid_i = 1'b1;
        data_i = 32'sd1000;
        @(posedge clk);
        #1;
        feed(32'sd0, 32);
        repeat (6) @(posedge clk);
        #1;
        check("part_count", outs.size(), 1);
        check("part_out0", outs[0], 0);

        // Reset asserted during FILT of the second block
        do_reset();
        feed(32'sd100, 64);
        check("mid_pre_count", outs.size(), 1);
        check("mid_pre_data", data_o, 12);
        #1;
        rst = 1'b0;
        #1;
        check("mid_data", data_o, 0);
        check("mid_valid", valid_o, 0);
        check("mid_sat", sat_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_post_count", outs.size(), 1);

        check("never_consecutive", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
